sparse_mult_frame_arbiter: RTL
==============================

Name: sparse_mult_frame_arbiter

Overview:
- Shares one sparse_mult_by_A datapath (96-bit words, 3x32-bit lanes) between NUM_REQ requesters.
- Each requester supplies frames of INPUT_LEN words. The datapath returns OUTPUT_LEN words per frame.
- The arbiter grants whole frames round-robin, never interleaves beats within a frame, and tracks outstanding frames in a tag FIFO. Each result word leaves tagged with the originating requester ID.
- Sits directly in front of and behind the multiplier instance.

Parameters:
- WIDTH, 96, data word width (three 32-bit lanes).
- NUM_REQ, 4, number of requesters (>=2).
- INPUT_LEN, 11, words per input frame.
- OUTPUT_LEN, 1, result words per frame.
- MAX_OUTSTANDING, 4, tag FIFO depth, i.e. max frames in flight inside the datapath.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_data  in  NUM_REQ*WIDTH  requester words; requester k occupies bits [k*WIDTH +: WIDTH].
- i_req_valid  in  NUM_REQ  per-requester valid.
- o_req_ready  out  NUM_REQ  per-requester ready.
- o_mult_data  out  WIDTH  input word to the datapath.
- o_mult_valid  out  1  valid to the datapath.
- i_mult_ready  in  1  ready from the datapath.
- i_mult_data  in  WIDTH  result word from the datapath.
- i_mult_valid  in  1  result valid.
- o_mult_ready  out  1  ready to the datapath output.
- o_output_data  out  WIDTH  tagged result word.
- o_output_id  out  ID_W  requester index; ID_W = max(1, $clog2(NUM_REQ)).
- o_output_valid  out  1  result valid downstream.
- i_output_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE, RR pointer = 0, beat counter = 0, tag FIFO empty, output-word counter = 0.
  - All outputs 0.
  - The datapath shares i_reset, so a reset mid-frame discards partial frames and all in-flight results.
- FSM IDLE:
  - Arbitrate when any i_req_valid is set and the tag FIFO is not full.
  - Round-robin search starts at the RR pointer; lowest index at or after the pointer wins.
  - Register the grant; go to STREAM next cycle. Arbitration costs 1 bubble cycle per frame.
  - If the FIFO is full, stay in IDLE with no grant.
- FSM STREAM:
  - o_mult_data = granted requester's data; o_mult_valid = i_req_valid[g].
  - o_req_ready[g] = i_mult_ready. All other o_req_ready = 0.
  - A beat transfers when valid & ready. Beat counter increments per transfer.
  - On the first beat of a frame, push g into the tag FIFO. The FIFO is guaranteed non-full by the IDLE check.
  - On the beat where counter == INPUT_LEN-1: counter resets to 0, RR pointer = g+1 mod NUM_REQ, return to IDLE.
  - A requester deasserting valid mid-frame only stalls; the grant is held until INPUT_LEN beats are complete. There is no timeout.
- Output path (combinational, independent of the FSM):
  - o_output_data = i_mult_data; o_output_id = FIFO head.
  - o_output_valid = i_mult_valid & !fifo_empty.
  - o_mult_ready = i_output_ready & !fifo_empty.
  - Each handshake increments the output-word counter. At OUTPUT_LEN-1 the counter wraps to 0 and the FIFO head pops.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.
- i_mult_valid while the FIFO is empty is a protocol violation: the word is held off (o_mult_ready = 0) and never dropped. SVA assertion flags it in simulation.
- No data arithmetic; words pass unmodified in both directions.
- Throughput: INPUT_LEN+1 cycles per frame when back-to-back.

Decomposition:
- Shared package sparse_mult_pkg holds:
  - constants WORD_WIDTH=96, LANE_WIDTH=32, INPUT_LEN=11, OUTPUT_LEN=1.
  - typedef for the 3-lane word struct (high/mid/low).
  - enum typedef for arbiter states {IDLE, STREAM}.
- One sub-module: sparse_mult_tag_fifo, a sync FIFO of ID_W x MAX_OUTSTANDING with full/empty flags and same-cycle push/pop.

Test Plan:
- Reset, no requests, i_output_ready=1 for 100 cycles -> all o_req_ready=0, o_mult_valid=0, o_output_valid=0.
- Requester 2 alone sends 11 words whose last word is {67108896,65536,134217792}, with a behavioural sparse_mult_by_A model -> exactly 1 output equal to {67108896,65536,134217792}, o_output_id=2.
- All 4 requesters valid continuously, 2 frames each -> grant order 0,1,2,3,0,1,2,3; output IDs in that order; no beat of one frame interleaved with another.
- i_output_ready=0 with 6 frames queued -> exactly MAX_OUTSTANDING=4 frames accepted, then no grants. Raise ready -> remaining 2 frames proceed and all 6 outputs are delivered.
- Requester 1 drops valid for 5 cycles after beat 4 while requester 3 is valid -> requester 3 stays ungranted until requester 1 finishes beat 11.
- Assert i_reset at beat 6 of a frame -> all outputs 0 immediately. After release, a fresh 11-word frame from requester 0 yields exactly 1 output with ID 0.

Source files
------------

// File: rtl/sparse_mult_pkg.sv
// Shared types and constants for the sparse_mult_by_A datapath and its frame arbiter.
package sparse_mult_pkg;

   localparam int unsigned WORD_WIDTH = 96;
   localparam int unsigned LANE_WIDTH = 32;
   localparam int unsigned INPUT_LEN  = 11;
   localparam int unsigned OUTPUT_LEN = 1;

   // One datapath word viewed as three 32-bit lanes, most significant lane first.
   typedef struct packed {
      logic [LANE_WIDTH-1:0] high;
      logic [LANE_WIDTH-1:0] mid;
      logic [LANE_WIDTH-1:0] low;
   } word_t;

   // Arbiter FSM: IDLE picks the next frame owner, STREAM forwards that owner's beats.
   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sparse_mult_tag_fifo.sv
// Small synchronous FIFO holding the requester ID of every frame inside the datapath.
module sparse_mult_tag_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Storage needs no reset; occupancy alone says which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap explicitly so non-power-of-two depths work; push+pop keeps count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sparse_mult_frame_arbiter.sv
// Round-robin whole-frame arbiter in front of a shared sparse_mult_by_A datapath;
// results come back tagged with the requester that sent the frame.
module sparse_mult_frame_arbiter #(
   parameter int unsigned WIDTH           = sparse_mult_pkg::WORD_WIDTH,
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned INPUT_LEN       = sparse_mult_pkg::INPUT_LEN,
   parameter int unsigned OUTPUT_LEN      = sparse_mult_pkg::OUTPUT_LEN,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   output logic [WIDTH-1:0]         o_mult_data,
   output logic                     o_mult_valid,
   input  logic                     i_mult_ready,
   input  logic [WIDTH-1:0]         i_mult_data,
   input  logic                     i_mult_valid,
   output logic                     o_mult_ready,
   output logic [WIDTH-1:0]         o_output_data,
   output logic [ID_W-1:0]          o_output_id,
   output logic                     o_output_valid,
   input  logic                     i_output_ready
);

   import sparse_mult_pkg::*;

   localparam int unsigned CNT_W  = (INPUT_LEN > 1) ? $clog2(INPUT_LEN) : 1;
   localparam int unsigned OCNT_W = (OUTPUT_LEN > 1) ? $clog2(OUTPUT_LEN) : 1;

   arb_state_t        state;
   arb_state_t        state_next;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   idx;
   logic              found;
   logic [CNT_W-1:0]  beat_cnt;
   logic [OCNT_W-1:0] out_cnt;
   logic              beat;
   logic              last_beat;
   logic              push;
   logic              pop;
   logic              out_hs;
   logic [ID_W-1:0]   fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WIDTH-1:0]  req_words [NUM_REQ];

   genvar g;
   for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_words[g] = i_req_data[g*WIDTH +: WIDTH];
   end

   // Round-robin search: first valid requester at or after the pointer wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
         if (!found && i_req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign beat      = o_mult_valid & i_mult_ready;
   assign last_beat = beat && (beat_cnt == CNT_W'(INPUT_LEN - 1));
   assign push      = beat && (beat_cnt == '0);

   // State register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   // Next state: grant only with tag space free; hold the grant until the frame is complete.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found && !fifo_full) state_next = STREAM;
         STREAM:  if (last_beat)           state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs toward requesters and datapath input: only the granted requester is connected.
   always_comb begin
      o_req_ready  = '0;
      o_mult_valid = 1'b0;
      o_mult_data  = '0;
      if (state == STREAM) begin
         o_mult_data        = req_words[grant];
         o_mult_valid       = i_req_valid[grant];
         o_req_ready[grant] = i_mult_ready;
      end
   end

   // Grant capture, beat counting and pointer advance past the finished owner.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == IDLE && state_next == STREAM) grant <= winner;
         if (beat) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
         if (last_beat) rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
   end

   // Result path: a word is only accepted when a tag says whose it is.
   assign o_output_valid = i_mult_valid & ~fifo_empty;
   assign o_mult_ready   = i_output_ready & ~fifo_empty;
   assign o_output_data  = fifo_empty ? '0 : i_mult_data;
   assign o_output_id    = fifo_empty ? '0 : fifo_head;
   assign out_hs         = i_mult_valid & o_mult_ready;
   assign pop            = out_hs && (out_cnt == OCNT_W'(OUTPUT_LEN - 1));

   // Count result words of the head frame; release its tag on the last one.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)     out_cnt <= '0;
      else if (out_hs) out_cnt <= pop ? '0 : out_cnt + OCNT_W'(1);
   end

   sparse_mult_tag_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk       (i_clock),
      .rst       (i_reset),
      .push      (push),
      .push_data (grant),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A result with no outstanding tag means the datapath broke protocol.
   a_no_result_without_tag: assert property (@(posedge i_clock) disable iff (i_reset)
      !(i_mult_valid && fifo_empty));

endmodule
